// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RISC-V instruction encoder: opcodes, format codes, NOP word.
// The same opcode values are decoded by the core's immediate generator.
package instr_encoder_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    // Shift-immediate forms reuse the I opcode but carry funct7 in the upper bits.
    function automatic fmt_e fmt_of(input logic [6:0] opcode, input logic [2:0] funct3);
        fmt_e f;
        case (opcode)
            OPC_OP_IMM:        f = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_ISH : FMT_I;
            OPC_LOAD, OPC_JALR: f = FMT_I;
            OPC_STORE:         f = FMT_S;
            OPC_BRANCH:        f = FMT_B;
            OPC_LUI:           f = FMT_U;
            OPC_JAL:           f = FMT_J;
            OPC_OP:            f = FMT_R;
            default:           f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_encoder_imm_range_check.sv
// Combinational check that a full 32-bit immediate is representable in its format.
// Only instantiated when IMM_RANGE_CHECK_EN is defined.
module imm_range_check
    import instr_encoder_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [31:0] imm,
    output logic        err
);

    logic i_fit_s;
    logic b_fit_s;
    logic j_fit_s;

    assign i_fit_s = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_fit_s = (&imm[31:12]) | ~(|imm[31:12]);
    assign j_fit_s = (&imm[31:20]) | ~(|imm[31:20]);

    // Per-format range / alignment decision
    always_comb begin
        err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: err = ~i_fit_s;
            FMT_ISH:      err = |imm[31:5];
            FMT_B:        err = ~b_fit_s | imm[0];
            FMT_J:        err = ~j_fit_s | imm[0];
            FMT_U:        err = |imm[11:0];
            default:      err = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage elastic RISC-V instruction encoder with an auto-incrementing output address.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    input  logic        addr_load,
    input  logic [31:0] addr_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err
);

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    fmt_e        fmt_s;
    logic        range_err_s;
    logic        s2_free_s;
    logic        s1_advance_s;
    logic        accept_s;
    logic [31:0] packed_s;

    logic        s1_valid_r;
    fmt_e        s1_fmt_r;
    logic        s1_err_r;
    logic [6:0]  s1_opcode_r;
    logic [4:0]  s1_rd_r;
    logic [4:0]  s1_rs1_r;
    logic [4:0]  s1_rs2_r;
    logic [2:0]  s1_funct3_r;
    logic [6:0]  s1_funct7_r;
    logic [31:0] s1_imm_r;

    assign fmt_s = fmt_of(in_opcode, in_funct3);

`ifdef IMM_RANGE_CHECK_EN
    imm_range_check u_range (
        .fmt (fmt_s),
        .imm (in_imm),
        .err (range_err_s)
    );
`else
    assign range_err_s = 1'b0;
`endif

    // Ready is forced low while reset is held so no bundle is taken during reset.
    assign s2_free_s    = ~out_valid | out_ready;
    assign s1_advance_s = s1_valid_r & s2_free_s;
    assign in_ready     = ~reset & (~s1_valid_r | s1_advance_s);
    assign accept_s     = in_valid & in_ready;

    // Stage 1: capture fields, format and error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r  <= 1'b0;
            s1_fmt_r    <= FMT_BAD;
            s1_err_r    <= 1'b0;
            s1_opcode_r <= 7'd0;
            s1_rd_r     <= 5'd0;
            s1_rs1_r    <= 5'd0;
            s1_rs2_r    <= 5'd0;
            s1_funct3_r <= 3'd0;
            s1_funct7_r <= 7'd0;
            s1_imm_r    <= 32'd0;
        end else if (accept_s) begin
            s1_valid_r  <= 1'b1;
            s1_fmt_r    <= fmt_s;
            s1_err_r    <= (fmt_s == FMT_BAD) | range_err_s;
            s1_opcode_r <= in_opcode;
            s1_rd_r     <= in_rd;
            s1_rs1_r    <= in_rs1;
            s1_rs2_r    <= in_rs2;
            s1_funct3_r <= in_funct3;
            s1_funct7_r <= in_funct7;
            s1_imm_r    <= in_imm;
        end else if (s1_advance_s) begin
            s1_valid_r  <= 1'b0;
        end
    end

    // Bit packing of the stage-1 fields into the instruction word
    always_comb begin
        packed_s = NOP_INSTR;
        case (s1_fmt_r)
            FMT_R:   packed_s = {s1_funct7_r, s1_rs2_r, s1_rs1_r, s1_funct3_r, s1_rd_r, s1_opcode_r};
            FMT_I:   packed_s = {s1_imm_r[11:0], s1_rs1_r, s1_funct3_r, s1_rd_r, s1_opcode_r};
            FMT_ISH: packed_s = {s1_funct7_r, s1_imm_r[4:0], s1_rs1_r, s1_funct3_r, s1_rd_r, s1_opcode_r};
            FMT_S:   packed_s = {s1_imm_r[11:5], s1_rs2_r, s1_rs1_r, s1_funct3_r, s1_imm_r[4:0], s1_opcode_r};
            FMT_B:   packed_s = {s1_imm_r[12], s1_imm_r[10:5], s1_rs2_r, s1_rs1_r, s1_funct3_r,
                                 s1_imm_r[4:1], s1_imm_r[11], s1_opcode_r};
            FMT_U:   packed_s = {s1_imm_r[31:12], s1_rd_r, s1_opcode_r};
            FMT_J:   packed_s = {s1_imm_r[20], s1_imm_r[10:1], s1_imm_r[11], s1_imm_r[19:12],
                                 s1_rd_r, s1_opcode_r};
            default: packed_s = NOP_INSTR;
        endcase
    end

    // Stage 2: output word register, held stable under backpressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_err   <= 1'b0;
        end else if (s1_advance_s) begin
            out_valid <= 1'b1;
            out_instr <= packed_s;
            out_err   <= s1_err_r;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Output address counter; an explicit load takes priority over the step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_addr <= ADDR_BASE;
        end else if (addr_load) begin
            out_addr <= addr_value;
        end else if (out_valid & out_ready) begin
            out_addr <= out_addr + STEP;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, backpressure, address
// counter behaviour, reset mid-stream and randomized traffic against a reference model.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [31:0] addr;
        logic [31:0] maddr;
        int          t;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = 7'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [6:0]  in_funct7 = 7'd0;
    logic [31:0] in_imm = 32'd0;
    logic        addr_load = 1'b0;
    logic [31:0] addr_value = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    rec_t exp_q[$];
    rec_t got_q[$];
    logic [31:0] model_cnt = BASE;

    instr_encoder #(.ADDR_BASE(BASE), .ADDR_STEP(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .addr_load(addr_load), .addr_value(addr_value), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference encoding from the format rules, using plain arithmetic on field values.
    function automatic rec_t model(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] imm, input int t);
        rec_t r;
        logic [31:0] w;
        logic bad, rng;
        int si;
        si = int'($signed(imm));
        bad = 1'b0;
        rng = 1'b0;
        w = 32'(op);
        case (op)
            7'b0110011: w = w + (32'(f7) << 25) + (32'(rs2) << 20) + (32'(rs1) << 15) + (32'(f3) << 12) + (32'(rd) << 7);
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w = w + (32'(rs1) << 15) + (32'(f3) << 12) + (32'(rd) << 7);
                if (op == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    w = w + (32'(f7) << 25) + ((imm % 32'd32) << 20);
                    rng = (imm > 32'd31);
                end else begin
                    w = w + ((imm % 32'd4096) << 20);
                    rng = (si < -2048) || (si > 2047);
                end
            end
            7'b0100011: begin
                w = w + (((imm / 32'd32) % 32'd128) << 25) + (32'(rs2) << 20) + (32'(rs1) << 15)
                      + (32'(f3) << 12) + ((imm % 32'd32) << 7);
                rng = (si < -2048) || (si > 2047);
            end
            7'b1100011: begin
                w = w + (((imm / 32'd4096) % 32'd2) << 31) + (((imm / 32'd32) % 32'd64) << 25)
                      + (32'(rs2) << 20) + (32'(rs1) << 15) + (32'(f3) << 12)
                      + (((imm / 32'd2) % 32'd16) << 8) + (((imm / 32'd2048) % 32'd2) << 7);
                rng = (si < -4096) || (si > 4095) || (imm % 32'd2 != 32'd0);
            end
            7'b0110111: begin
                w = w + (imm / 32'd4096) * 32'd4096 + (32'(rd) << 7);
                rng = (imm % 32'd4096) != 32'd0;
            end
            7'b1101111: begin
                w = w + (((imm / 32'd1048576) % 32'd2) << 31) + (((imm / 32'd2) % 32'd1024) << 21)
                      + (((imm / 32'd2048) % 32'd2) << 20) + (((imm / 32'd4096) % 32'd256) << 12) + (32'(rd) << 7);
                rng = (si < -1048576) || (si > 1048575) || (imm % 32'd2 != 32'd0);
            end
            default: begin
                w = 32'h0000_0013;
                bad = 1'b1;
            end
        endcase
        r.instr = w;
        r.err = bad | (RC & rng);
        r.addr = 32'd0;
        r.maddr = 32'd0;
        r.t = t;
        return r;
    endfunction

    // Immediate recovered from an encoded word, as the core's immediate generator does.
    function automatic logic [31:0] dec_imm(input logic [31:0] w);
        case (w[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: dec_imm = {{20{w[31]}}, w[31:20]};
            7'b0100011: dec_imm = {{20{w[31]}}, w[31:25], w[11:7]};
            7'b1100011: dec_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            7'b0110111: dec_imm = {w[31:12], 12'd0};
            7'b1101111: dec_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:    dec_imm = 32'd0;
        endcase
    endfunction

    // Record accepted inputs (through the model) and emitted words, plus the model address counter.
    always @(negedge clk) begin
        if (reset) begin
            model_cnt <= BASE;
        end else begin
            if (in_valid && in_ready)
                exp_q.push_back(model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, cyc));
            if (out_valid && out_ready)
                got_q.push_back(rec_t'{out_instr, out_err, out_addr, model_cnt, cyc});
            if (addr_load)
                model_cnt <= addr_value;
            else if (out_valid && out_ready)
                model_cnt <= model_cnt + 32'd4;
        end
    end

    task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm);
        bit ok;
        ok = 1'b0;
        set_fields(op, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL send_timeout got in_ready=0 want 1"); end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 200) begin @(negedge clk); #1; k++; end
        checks++;
        if (got_q.size() < n) begin errors++; $display("FAIL wait_got got %0d want %0d", got_q.size(), n); end
    endtask

    task automatic apply_item(input int i);
        case (i)
            0:       set_fields(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
            1:       set_fields(7'b0000011, 5'd4, 5'd5, 5'd0, 3'd2, 7'd0, 32'd12);
            2:       set_fields(7'b0010011, 5'd6, 5'd7, 5'd0, 3'd1, 7'd0, 32'd3);
            default: set_fields(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        endcase
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL rst_out_instr got %h want 0", out_instr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err got %b want 0", out_err); end
        checks++; if (out_addr !== BASE) begin errors++; $display("FAIL rst_out_addr got %h want %h", out_addr, BASE); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_addi();
        rec_t g, e;
        out_ready = 1'b1;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        wait_got(1);
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g.instr !== 32'h0050_0093) begin errors++; $display("FAIL addi_instr got %h want 00500093", g.instr); end
            checks++; if (g.err !== 1'b0) begin errors++; $display("FAIL addi_err got %b want 0", g.err); end
            checks++; if (g.addr !== BASE) begin errors++; $display("FAIL addi_addr got %h want %h", g.addr, BASE); end
            checks++; if (g.t - e.t != 2) begin errors++; $display("FAIL addi_latency got %0d want 2", g.t - e.t); end
            checks++; if (dec_imm(g.instr) !== 32'd5) begin errors++; $display("FAIL addi_roundtrip got %h want 5", dec_imm(g.instr)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        rec_t g0, g1;
        send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        wait_got(2);
        if (got_q.size() > 1) begin
            g0 = got_q.pop_front(); g1 = got_q.pop_front();
            void'(exp_q.pop_front()); void'(exp_q.pop_front());
            checks++; if (g0.instr !== 32'h0020_A423) begin errors++; $display("FAIL sw_instr got %h want 0020a423", g0.instr); end
            checks++; if (g1.instr !== 32'hFE20_8EE3) begin errors++; $display("FAIL beq_instr got %h want fe208ee3", g1.instr); end
            checks++; if (g1.t != g0.t + 1) begin errors++; $display("FAIL b2b_cycles got %0d want %0d", g1.t, g0.t + 1); end
            checks++; if (g0.addr !== BASE + 32'd4) begin errors++; $display("FAIL sw_addr got %h want %h", g0.addr, BASE + 32'd4); end
            checks++; if (g1.addr !== g0.addr + 32'd4) begin errors++; $display("FAIL beq_addr got %h want %h", g1.addr, g0.addr + 32'd4); end
            checks++; if (dec_imm(g0.instr) !== 32'd8) begin errors++; $display("FAIL sw_roundtrip got %h want 8", dec_imm(g0.instr)); end
            checks++; if (dec_imm(g1.instr) !== 32'hFFFF_FFFC) begin errors++; $display("FAIL beq_roundtrip got %h want fffffffc", dec_imm(g1.instr)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_jal_lui();
        rec_t g0, g1;
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        wait_got(2);
        if (got_q.size() > 1) begin
            g0 = got_q.pop_front(); g1 = got_q.pop_front();
            void'(exp_q.pop_front()); void'(exp_q.pop_front());
            checks++; if (g0.instr !== 32'h0080_00EF) begin errors++; $display("FAIL jal_instr got %h want 008000ef", g0.instr); end
            checks++; if (g1.instr !== 32'h1234_52B7) begin errors++; $display("FAIL lui_instr got %h want 123452b7", g1.instr); end
            checks++; if (dec_imm(g0.instr) !== 32'd8) begin errors++; $display("FAIL jal_roundtrip got %h want 8", dec_imm(g0.instr)); end
            checks++; if (dec_imm(g1.instr) !== 32'h1234_5000) begin errors++; $display("FAIL lui_roundtrip got %h want 12345000", dec_imm(g1.instr)); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_imm_edge();
        rec_t g0, g1;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        wait_got(2);
        if (got_q.size() > 1) begin
            g0 = got_q.pop_front(); g1 = got_q.pop_front();
            void'(exp_q.pop_front()); void'(exp_q.pop_front());
            checks++; if (g0.instr !== 32'h8000_0093) begin errors++; $display("FAIL imm2048_instr got %h want 80000093", g0.instr); end
            checks++; if (g0.err !== RC) begin errors++; $display("FAIL imm2048_err got %b want %b", g0.err, RC); end
            checks++; if (g1.instr !== 32'h0000_0013) begin errors++; $display("FAIL badop_instr got %h want 00000013", g1.instr); end
            checks++; if (g1.err !== 1'b1) begin errors++; $display("FAIL badop_err got %b want 1", g1.err); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int idx;
        logic [65:0] snap;
        rec_t g, e;
        idx = 0;
        snap = 66'd0;
        out_ready = 1'b0;
        apply_item(0);
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (c == 2) snap = {out_valid, out_err, out_instr, out_addr};
            if (c == 7) begin
                checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", idx); end
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
                checks++;
                if ({out_valid, out_err, out_instr, out_addr} !== snap) begin
                    errors++; $display("FAIL bp_stable got %h want %h", {out_valid, out_err, out_instr, out_addr}, snap);
                end
            end
            @(posedge clk); #1;
            if (idx < 3) apply_item(idx); else in_valid = 1'b0;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            if (idx < 3) apply_item(idx); else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        wait_got(3);
        repeat (4) @(negedge clk);
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g.instr !== e.instr) begin errors++; $display("FAIL bp_instr got %h want %h", g.instr, e.instr); end
            checks++; if (g.addr !== g.maddr) begin errors++; $display("FAIL bp_addr got %h want %h", g.addr, g.maddr); end
        end
        got_q.delete(); exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_addr_load();
        rec_t g0, g1;
        out_ready = 1'b0;
        send(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        send(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        out_ready = 1'b1; addr_load = 1'b1; addr_value = 32'hDEAD_BEE0;
        @(posedge clk); #1;
        addr_load = 1'b0;
        wait_got(2);
        if (got_q.size() > 1) begin
            g0 = got_q.pop_front(); g1 = got_q.pop_front();
            checks++; if (g0.addr !== g0.maddr) begin errors++; $display("FAIL load_first_addr got %h want %h", g0.addr, g0.maddr); end
            checks++; if (g1.addr !== 32'hDEAD_BEE0) begin errors++; $display("FAIL load_win_addr got %h want deadbee0", g1.addr); end
        end
        got_q.delete(); exp_q.delete();
        @(posedge clk); #1;
        addr_load = 1'b1; addr_value = 32'hFFFF_FFFC;
        @(posedge clk); #1;
        addr_load = 1'b0;
        send(7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        send(7'b0110011, 5'd4, 5'd5, 5'd6, 3'd7, 7'h20, 32'd0);
        wait_got(2);
        if (got_q.size() > 1) begin
            g0 = got_q.pop_front(); g1 = got_q.pop_front();
            checks++; if (g0.addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre_addr got %h want fffffffc", g0.addr); end
            checks++; if (g1.addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_post_addr got %h want 00000000", g1.addr); end
        end
        got_q.delete(); exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [6:0] ops[9];
        int sent, n;
        bit acc;
        rec_t g, e;
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b1101111, 7'b0110011, 7'h7F};
        sent = 0;
        n = 150;
        for (int c = 0; c < 3000 && sent < n; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_opcode = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
                in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
                in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
                case ($urandom_range(0, 3))
                    0:       in_imm = $urandom;
                    1:       in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                    2:       in_imm = $urandom & 32'hFFFF_F000;
                    default: in_imm = 32'($urandom_range(0, 40));
                endcase
                in_valid = 1'b1;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent++;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_got(n);
        repeat (4) @(negedge clk);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++; if (g.instr !== e.instr) begin errors++; $display("FAIL rand_instr got %h want %h", g.instr, e.instr); end
            checks++; if (g.err !== e.err) begin errors++; $display("FAIL rand_err got %b want %b (instr %h)", g.err, e.err, e.instr); end
            checks++; if (g.addr !== g.maddr) begin errors++; $display("FAIL rand_addr got %h want %h", g.addr, g.maddr); end
        end
        got_q.delete(); exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream();
        addr_load = 1'b1; addr_value = 32'h5555_0000;
        @(posedge clk); #1;
        addr_load = 1'b0;
        out_ready = 1'b0;
        send(7'b0110111, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready got %b want 0", in_ready); end
        checks++; if (out_addr !== BASE) begin errors++; $display("FAIL mid_out_addr got %h want %h", out_addr, BASE); end
        checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL mid_out_instr got %h want 0", out_instr); end
        exp_q.delete(); got_q.delete();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_emitted got %0d want 0", got_q.size()); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_post_valid got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_jal_lui();
        test_imm_edge();
        test_backpressure();
        test_addr_load();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RISC-V instruction encoder: the inverse of the core's immediate generator. Accepts decoded fields (opcode, registers, functs, full 32-bit immediate) over a valid/ready handshake and packs them into a 32-bit instruction word. Each packed word is tagged with an auto-incrementing byte address. It sits in the program-loader / self-test path ahead of instruction memory writes.

## Interface
Parameters:
- ADDR_BASE, 32'h0000_0000, reset value of the output address counter
- ADDR_STEP, 4, address increment per accepted output word

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept the bundle
- in_opcode  input  7  instruction opcode
- in_rd / in_rs1 / in_rs2  input  5 each  register indices
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7
- in_imm  input  32  sign-extended immediate, in byte units for B and J
- addr_load  input  1  load the address counter
- addr_value  input  32  value loaded by addr_load
- out_valid  output  1  encoded word valid
- out_ready  input  1  downstream accepts the word
- out_instr  output  32  encoded instruction
- out_addr  output  32  address tagged to out_instr
- out_err  output  1  immediate out of range or unsupported opcode

## Operation
- Format is selected from in_opcode:
  - I: 0010011, 0000011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111
  - J: 1101111
  - R: 0110011
  - any other opcode is unsupported
- Packing:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - I shift (opcode 0010011, funct3 001 or 101): {funct7, imm[4:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - unsupported opcode: 32'h0000_0013 (NOP), out_err = 1
- Two-stage elastic pipeline:
  - S1 registers the fields, the format code and the range-check result.
  - S2 registers the packed word, out_err and out_addr.
- Each stage advances when its downstream slot is empty or being drained. in_ready = !s1_valid | s1_advance.
- Address counter:
  - out_addr holds the current counter value while out_valid = 1.
  - The counter increments by ADDR_STEP on each out_valid & out_ready.
  - addr_load sets the counter to addr_value. If addr_load coincides with an output handshake, the load wins.
  - The counter wraps modulo 2^32.

## Timing
- Latency: 2 cycles from input handshake to out_valid. Throughput is 1 word/cycle while out_ready stays high.
- Backpressure:
  - With out_ready low, out_valid, out_instr, out_addr and out_err hold stable.
  - S1 still fills, so at most 2 bundles are buffered before in_ready deasserts.
- Simultaneous drain and refill of a stage in the same cycle is allowed, with no bubble.
- Reset values: in_ready = 0 while reset is high and 1 in the first cycle after release; out_valid = 0, out_instr = 0, out_err = 0, counter = ADDR_BASE. Both stage valids clear immediately.
- Reset asserted mid-stream discards in-flight words; none are emitted after release.
- in_* are sampled only on in_valid & in_ready.

## Configuration
- IMM_RANGE_CHECK_EN defined:
  - out_err = 1 when the immediate does not fit its format:
    - I/S: imm[31:11] not all equal
    - I shift: imm[31:5] != 0
    - B: imm[31:12] not all equal, or imm[0] = 1
    - J: imm[31:20] not all equal, or imm[0] = 1
    - U: imm[11:0] != 0
  - The word is still emitted, packed from the truncated bits.
- IMM_RANGE_CHECK_EN undefined:
  - No range logic; immediates are truncated silently.
  - out_err is raised only for an unsupported opcode.

## Structure
- A shared package holds:
  - the opcode constants (same values the immediate generator decodes)
  - the format enum: FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
  - the NOP constant
- One sub-module, imm_range_check: combinational, (format, imm) → error. It is instantiated only under IMM_RANGE_CHECK_EN.

## Test plan
- addi x1,x0,5 (0010011, rd=1, imm=5) → out_instr 32'h0050_0093, out_addr = ADDR_BASE, out_valid exactly 2 cycles after the input handshake.
- sw x2,8(x1), then beq x1,x2,-4, back-to-back → 32'h0020_A423 then 32'hFE20_8EE3 on consecutive cycles, out_addr stepping by 4.
- jal x1,+8 → 32'h0080_00EF. lui x5,0x12345000 → 32'h1234_52B7. Each decoded word fed back through immediate_generator returns the original immediate.
- addi with imm = 2048:
  - macro defined: out_err = 1, out_instr = 32'h8000_0093
  - macro undefined: out_err = 0, same word
- out_ready held low for 5 cycles with in_valid high → in_ready drops after 2 accepted bundles, outputs stay stable, no word is lost or duplicated after release. Also addr_load coincident with a handshake → next out_addr = addr_value.
- Opcode 7'h7F → out_instr 32'h0000_0013, out_err = 1. Reset asserted with 2 words in flight → out_valid = 0 immediately, counter = ADDR_BASE.
